// File: rtl/tl_ul_ram_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : tl_ul_ram_responder_if
// Description : TileLink-UL A/D channel bundle between a master and the
//               memory-backed responder.
//               master modport: drives the A channel and d_ready.
//               slave modport : drives a_ready and the D channel.
// Revision    : 1.0 - initial release
// ============================================================================
interface tl_ul_ram_responder_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int SRC_W  = 7,
    parameter int SIZE_W = 4
);
    // A channel
    logic                  a_valid;
    logic                  a_ready;
    logic [2:0]            a_opcode;
    logic [2:0]            a_param;
    logic [SIZE_W-1:0]     a_size;
    logic [SRC_W-1:0]      a_source;
    logic [ADDR_W-1:0]     a_address;
    logic [DATA_W/8-1:0]   a_mask;
    logic [DATA_W-1:0]     a_data;
    logic                  a_corrupt;
    // D channel
    logic                  d_valid;
    logic                  d_ready;
    logic [2:0]            d_opcode;
    logic [1:0]            d_param;
    logic [SIZE_W-1:0]     d_size;
    logic [SRC_W-1:0]      d_source;
    logic                  d_sink;
    logic                  d_denied;
    logic [DATA_W-1:0]     d_data;
    logic                  d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address,
               a_mask, a_data, a_corrupt, d_ready,
        input  a_ready, d_valid, d_opcode, d_param, d_size, d_source,
               d_sink, d_denied, d_data, d_corrupt
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address,
               a_mask, a_data, a_corrupt, d_ready,
        output a_ready, d_valid, d_opcode, d_param, d_size, d_source,
               d_sink, d_denied, d_data, d_corrupt
    );
endinterface
`default_nettype wire

// File: rtl/tl_ul_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tl_ul_ram_responder
// Description : TileLink-UL slave backed by a word RAM. Single-beat A-channel
//               requests are classified on acceptance, the RAM is accessed in
//               the same cycle, and the response is pushed into a 2-entry
//               in-order queue that feeds the D channel. Out-of-range,
//               multi-beat and unsupported requests get denied responses.
// Ports       : clock - single clock, rising edge
//               reset - asynchronous, active-high; empties the response queue
//               tl    - slave modport of tl_ul_ram_responder_if (A and D)
// Options     : TL_RESP_BACKPRESSURE_EN - when defined, an 8-bit LFSR
//               randomly deasserts a_ready to exercise master stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_ul_ram_responder #(
    parameter int                ADDR_W = 30,
    parameter int                DATA_W = 32,
    parameter int                SRC_W  = 7,
    parameter int                SIZE_W = 4,
    parameter int                MEM_AW = 10,
    parameter logic [ADDR_W-1:0] BASE   = '0
) (
    input  wire                   clock,
    input  wire                   reset,
    tl_ul_ram_responder_if.slave  tl
);
    localparam int MASK_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(MASK_W);
    localparam int DEPTH  = 1 << MEM_AW;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_ARITH       = 3'd2;
    localparam logic [2:0] OP_LOGIC       = 3'd3;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_HINT        = 3'd5;

    localparam logic [2:0] D_ACK          = 3'd0;
    localparam logic [2:0] D_ACK_DATA     = 3'd1;
    localparam logic [2:0] D_HINT_ACK     = 3'd2;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [SIZE_W-1:0] size;
        logic [SRC_W-1:0]  source;
        logic              denied;
        logic [DATA_W-1:0] data;
        logic              corrupt;
    } rsp_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];
    rsp_t [1:0]        entry_q, entry_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    logic              w_a_ready;
    logic              w_a_fire;
    logic              w_d_fire;

    // ------------------------------------------------------------------
    // Request classification
    // ------------------------------------------------------------------
    // The subtraction carries an extra borrow bit so "address below BASE"
    // falls out of the same arithmetic as the upper-bound test.
    logic              w_borrow;
    logic [ADDR_W-1:0] w_offset;
    logic [MEM_AW-1:0] w_word;
    logic              w_in_range;
    logic              w_single;
    logic              w_ok;
    logic              w_we;
    rsp_t              w_rsp;

    assign {w_borrow, w_offset} = {1'b0, tl.a_address} - {1'b0, BASE};
    assign w_word     = w_offset[OFF_W+MEM_AW-1:OFF_W];
    assign w_in_range = !w_borrow && (w_offset[ADDR_W-1:OFF_W+MEM_AW] == '0);
    assign w_single   = (tl.a_size <= SIZE_W'(OFF_W));
    assign w_ok       = w_in_range && w_single;

    always_comb begin
        w_rsp         = '0;
        w_rsp.opcode  = D_ACK;
        w_rsp.size    = tl.a_size;
        w_rsp.source  = tl.a_source;
        w_we          = 1'b0;
        case (tl.a_opcode)
            OP_GET: begin
                w_rsp.opcode = D_ACK_DATA;
                if (w_ok) begin
                    w_rsp.data = mem[w_word];
                end else begin
                    w_rsp.denied  = 1'b1;
                    w_rsp.corrupt = 1'b1;
                end
            end
            OP_PUT_FULL, OP_PUT_PARTIAL: begin
                if (w_ok) begin
                    w_we = w_a_fire;
                end else begin
                    w_rsp.denied = 1'b1;
                end
            end
            OP_ARITH, OP_LOGIC: begin
                w_rsp.opcode  = D_ACK_DATA;
                w_rsp.denied  = 1'b1;
                w_rsp.corrupt = 1'b1;
            end
            OP_HINT: begin
                w_rsp.opcode = D_HINT_ACK;
            end
            default: begin
                w_rsp.denied = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RAM: combinational read above, byte-lane synchronous write here.
    // A Get in the cycle after a Put reads the already-updated word.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_we) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (tl.a_mask[i]) begin
                    mem[w_word][8*i +: 8] <= tl.a_data[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional random backpressure on the A channel
    // ------------------------------------------------------------------
`ifdef TL_RESP_BACKPRESSURE_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign w_a_ready = (count_q != 2'd2) && (lfsr_q[1:0] != 2'b00);
`else
    assign w_a_ready = (count_q != 2'd2);
`endif

    assign w_a_fire = tl.a_valid && w_a_ready;
    assign w_d_fire = (count_q != 2'd0) && tl.d_ready;

    // ------------------------------------------------------------------
    // Response queue
    // ------------------------------------------------------------------
    always_comb begin
        entry_d  = entry_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_a_fire) begin
            entry_d[wr_ptr_q] = w_rsp;
            wr_ptr_d          = ~wr_ptr_q;
        end
        if (w_d_fire) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({w_a_fire, w_d_fire})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entry_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            entry_q  <= entry_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: D payload is always the head entry, so it holds while stalled
    // ------------------------------------------------------------------
    assign tl.a_ready   = w_a_ready;
    assign tl.d_valid   = (count_q != 2'd0);
    assign tl.d_opcode  = entry_q[rd_ptr_q].opcode;
    assign tl.d_param   = 2'd0;
    assign tl.d_size    = entry_q[rd_ptr_q].size;
    assign tl.d_source  = entry_q[rd_ptr_q].source;
    assign tl.d_sink    = 1'b0;
    assign tl.d_denied  = entry_q[rd_ptr_q].denied;
    assign tl.d_data    = entry_q[rd_ptr_q].data;
    assign tl.d_corrupt = entry_q[rd_ptr_q].corrupt;

    // a_param carries nothing for UL; a_corrupt does not block the write.
    logic w_unused;
    assign w_unused = ^{tl.a_param, tl.a_corrupt, w_offset[OFF_W-1:0]};

endmodule
`default_nettype wire
